pu_or1k_pfpu32_i2f_rnd: RTL and testbench
=========================================

Name: pu_or1k_pfpu32_i2f_rnd

Overview:
- Back end of the int-to-float conversion path in the PFPU32 unit.
- Consumes the registered stage-1 i2f outputs (magnitude, sign, precomputed shift amounts and exponents).
- Stage A aligns the mantissa and derives guard/sticky bits. Stage B rounds and packs an IEEE-754 single.
- Moves in lock-step with the FPU pipeline via adv_i/flush_i. Result goes to the FPU result mux.

Parameters:
- None. Widths are fixed by the single-precision format.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush_i  in  1  flush pipe; kills in-flight ops
- adv_i  in  1  advance pipe; all registers update only when high
- rnd_mode_i  in  2  rounding mode: 0 nearest-even, 1 toward zero, 2 toward +inf, 3 toward -inf
- i2f_rdy_i  in  1  stage-1 result valid
- i2f_sign_i  in  1  sign of integer
- i2f_shr_i  in  4  right-shift amount, 0..8
- i2f_exp8shr_i  in  8  exponent when right-shifting
- i2f_shl_i  in  5  left-shift amount, 0..23
- i2f_exp8shl_i  in  8  exponent when left-shifting
- i2f_exp8sh0_i  in  8  exponent when no shift (150 or 0)
- i2f_fract32_i  in  32  integer magnitude
- rdy_o  out  1  result valid
- result_o  out  32  packed float {sign, exp[7:0], fract[22:0]}
- ix_o  out  1  inexact flag
- zero_o  out  1  result is +0

Behaviour:
- Reset: rst is synchronous, active-high; clock clk. All registers and outputs are 0 (rdy_o=0, result_o=0, ix_o=0, zero_o=0).
- Latency: exactly 2 adv_i cycles from i2f_rdy_i to rdy_o. adv_i low freezes both stages, including rdy flags.
- Valid chain: on adv_i, rdyA<=i2f_rdy_i and rdy_o<=rdyA.
- Flush: flush_i clears rdyA and rdy_o next edge and has priority over adv_i. Data regs need not clear.
- Stage A, registered on adv_i; rnd_mode_i is captured here and travels with the op. Mantissa m24 / exponent e selection:
  - shr!=0: m24 = fract32>>shr, e = exp8shr. g = fract32[shr-1]; s = OR of fract32 bits below shr-1 (s=0 when shr=1).
  - else if fract32[23]=1: m24 = fract32[23:0], e = exp8sh0, g=s=0.
  - else if fract32!=0: m24 = fract32[23:0]<<shl, e = exp8shl, g=s=0.
  - else (zero): m24=0, e=0, g=s=0; zeroA=1.
  - Also register signA.
- Stage B, registered on adv_i. Round-up:
  - RNE: up = g&(s|m24[0]).
  - RTZ: up = 0.
  - +inf: up = (g|s)&~sign.
  - -inf: up = (g|s)&sign.
- Arithmetic: m25 = m24 + up. If m25[24] carries out, the mantissa becomes 1.0 (fract=0) and e+1.
  - No overflow is possible: max e after increment is 158.
- Outputs:
  - result_o = {sign, e, m[22:0]}.
  - ix_o = g|s.
  - zero_o = zeroA.
  - Zero input always yields 0x00000000 (sign forced 0).
- Simultaneous flush and i2f_rdy_i: flush wins; the op is dropped.
- Back-to-back ops with adv_i=1 every cycle: one result per cycle.

Optional Feature:
- Macro: PFPU32_I2F_DIRECTED_RND_EN.
- Defined: all four rounding modes are honoured as above.
- Undefined: rnd_mode_i is ignored and always treated as nearest-even; the stage-A mode register is removed.

Test Plan:
- opa=1 (fract32=1, shl=23, exp8shl=127), adv_i=1 -> result_o=0x3F800000, ix_o=0, rdy_o high exactly 2 cycles after i2f_rdy_i.
- opa=0x80000000 (fract32=0x80000000, sign=1, shr=8, exp8shr=158) -> result_o=0xCF000000, ix_o=0.
- opa=0x01000001, shr=1, exp8shr=151 -> result_o depends on mode, ix_o=1 in all cases:
  - rm=0: 0x4B800000.
  - rm=2: 0x4B800001 (feature on).
  - rm=3: 0x4B800000.
- opa=0x7FFFFFFF, shr=7, rm=0 -> mantissa carry-out -> result_o=0x4F000000, ix_o=1.
- opa=0 (fract32=0, exp8sh0=0) -> result_o=0x00000000, zero_o=1, ix_o=0.
- Control cases:
  - i2f_rdy_i then flush_i one cycle later -> rdy_o never asserts.
  - adv_i held low 3 cycles mid-pipe -> outputs and rdy frozen, then resume with correct result.

Source files
------------

// File: rtl/pu_or1k_pfpu32_i2f_rnd.sv
// PFPU32 int-to-float back end: stage A aligns the mantissa and derives guard/sticky,
// stage B rounds and packs. Define PFPU32_I2F_DIRECTED_RND_EN to honour all four rounding modes.
module pu_or1k_pfpu32_i2f_rnd (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_i,
   input  logic        adv_i,
   input  logic [1:0]  rnd_mode_i,
   input  logic        i2f_rdy_i,
   input  logic        i2f_sign_i,
   input  logic [3:0]  i2f_shr_i,
   input  logic [7:0]  i2f_exp8shr_i,
   input  logic [4:0]  i2f_shl_i,
   input  logic [7:0]  i2f_exp8shl_i,
   input  logic [7:0]  i2f_exp8sh0_i,
   input  logic [31:0] i2f_fract32_i,
   output logic        rdy_o,
   output logic [31:0] result_o,
   output logic        ix_o,
   output logic        zero_o
);

   typedef enum logic [1:0] {
      RM_NEAREST = 2'd0,
      RM_ZERO    = 2'd1,
      RM_UP      = 2'd2,
      RM_DOWN    = 2'd3
   } rnd_mode_e;

   // stage A state
   logic        rdy_a_q,  rdy_a_d;
   logic        sign_a_q, sign_a_d;
   logic        zero_a_q, zero_a_d;
   logic        g_a_q,    g_a_d;
   logic        s_a_q,    s_a_d;
   logic [23:0] m24_a_q,  m24_a_d;
   logic [7:0]  exp_a_q,  exp_a_d;
`ifdef PFPU32_I2F_DIRECTED_RND_EN
   logic [1:0]  rm_a_q,   rm_a_d;
`endif

   // stage B state
   logic        rdy_b_q,  rdy_b_d;
   logic [31:0] res_b_q,  res_b_d;
   logic        ix_b_q,   ix_b_d;
   logic        zero_b_q, zero_b_d;

   // alignment helpers
   logic [3:0]  shr_m1;
   logic [7:0]  g_mask;
   logic [7:0]  s_mask;
   logic [23:0] m24_shr;
   logic [23:0] m24_shl;

   assign shr_m1  = i2f_shr_i - 4'd1;
   // Guard is the last bit shifted out; sticky collects everything below it.
   assign g_mask  = (i2f_shr_i == 4'd0) ? 8'd0 : (8'd1 << shr_m1);
   assign s_mask  = g_mask - 8'd1;
   assign m24_shr = 24'(i2f_fract32_i >> i2f_shr_i);
   assign m24_shl = i2f_fract32_i[23:0] << i2f_shl_i;

   // stage A next state
   always_comb begin
      rdy_a_d  = rdy_a_q;
      sign_a_d = sign_a_q;
      zero_a_d = zero_a_q;
      g_a_d    = g_a_q;
      s_a_d    = s_a_q;
      m24_a_d  = m24_a_q;
      exp_a_d  = exp_a_q;
`ifdef PFPU32_I2F_DIRECTED_RND_EN
      rm_a_d   = rm_a_q;
`endif
      if (adv_i) begin
         rdy_a_d  = i2f_rdy_i;
         sign_a_d = i2f_sign_i;
         zero_a_d = 1'b0;
         g_a_d    = 1'b0;
         s_a_d    = 1'b0;
`ifdef PFPU32_I2F_DIRECTED_RND_EN
         rm_a_d   = rnd_mode_i;
`endif
         if (i2f_shr_i != 4'd0) begin
            m24_a_d = m24_shr;
            exp_a_d = i2f_exp8shr_i;
            g_a_d   = |(i2f_fract32_i[7:0] & g_mask);
            s_a_d   = |(i2f_fract32_i[7:0] & s_mask);
         end else if (i2f_fract32_i[23]) begin
            m24_a_d = i2f_fract32_i[23:0];
            exp_a_d = i2f_exp8sh0_i;
         end else if (i2f_fract32_i != 32'd0) begin
            m24_a_d = m24_shl;
            exp_a_d = i2f_exp8shl_i;
         end else begin
            m24_a_d  = 24'd0;
            exp_a_d  = 8'd0;
            zero_a_d = 1'b1;
         end
      end
      if (flush_i) rdy_a_d = 1'b0;
   end

   // rounding
   rnd_mode_e   rm_eff;
   logic        up;
   logic [24:0] m25;
   logic [7:0]  exp_rnd;
   logic        unused_hidden;

`ifdef PFPU32_I2F_DIRECTED_RND_EN
   assign rm_eff = rnd_mode_e'(rm_a_q);
`else
   logic unused_rnd_mode;
   assign unused_rnd_mode = ^rnd_mode_i;
   assign rm_eff          = RM_NEAREST;
`endif

   always_comb begin
      case (rm_eff)
         RM_NEAREST: up = g_a_q & (s_a_q | m24_a_q[0]);
         RM_ZERO:    up = 1'b0;
         RM_UP:      up = (g_a_q | s_a_q) & ~sign_a_q;
         default:    up = (g_a_q | s_a_q) & sign_a_q;
      endcase
   end

   // A carry-out leaves m25[22:0] all zero, so the fraction needs no extra mux.
   assign m25           = {1'b0, m24_a_q} + {24'd0, up};
   assign exp_rnd       = exp_a_q + {7'd0, m25[24]};
   assign unused_hidden = m25[23];

   // stage B next state
   always_comb begin
      rdy_b_d  = rdy_b_q;
      res_b_d  = res_b_q;
      ix_b_d   = ix_b_q;
      zero_b_d = zero_b_q;
      if (adv_i) begin
         rdy_b_d  = rdy_a_q;
         res_b_d  = {sign_a_q & ~zero_a_q, exp_rnd, m25[22:0]};
         ix_b_d   = g_a_q | s_a_q;
         zero_b_d = zero_a_q;
      end
      if (flush_i) rdy_b_d = 1'b0;
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_a_q  <= 1'b0;
         sign_a_q <= 1'b0;
         zero_a_q <= 1'b0;
         g_a_q    <= 1'b0;
         s_a_q    <= 1'b0;
         m24_a_q  <= 24'd0;
         exp_a_q  <= 8'd0;
`ifdef PFPU32_I2F_DIRECTED_RND_EN
         rm_a_q   <= 2'd0;
`endif
         rdy_b_q  <= 1'b0;
         res_b_q  <= 32'd0;
         ix_b_q   <= 1'b0;
         zero_b_q <= 1'b0;
      end else begin
         rdy_a_q  <= rdy_a_d;
         sign_a_q <= sign_a_d;
         zero_a_q <= zero_a_d;
         g_a_q    <= g_a_d;
         s_a_q    <= s_a_d;
         m24_a_q  <= m24_a_d;
         exp_a_q  <= exp_a_d;
`ifdef PFPU32_I2F_DIRECTED_RND_EN
         rm_a_q   <= rm_a_d;
`endif
         rdy_b_q  <= rdy_b_d;
         res_b_q  <= res_b_d;
         ix_b_q   <= ix_b_d;
         zero_b_q <= zero_b_d;
      end
   end

   assign rdy_o    = rdy_b_q;
   assign result_o = res_b_q;
   assign ix_o     = ix_b_q;
   assign zero_o   = zero_b_q;

endmodule

// File: tb/tb_pu_or1k_pfpu32_i2f_rnd.sv
// Scoreboard bench for pu_or1k_pfpu32_i2f_rnd: directed, control and randomised conversions.
module tb_pu_or1k_pfpu32_i2f_rnd;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i;
   logic        adv_i;
   logic [1:0]  rnd_mode_i;
   logic        i2f_rdy_i;
   logic        i2f_sign_i;
   logic [3:0]  i2f_shr_i;
   logic [7:0]  i2f_exp8shr_i;
   logic [4:0]  i2f_shl_i;
   logic [7:0]  i2f_exp8shl_i;
   logic [7:0]  i2f_exp8sh0_i;
   logic [31:0] i2f_fract32_i;
   logic        rdy_o;
   logic [31:0] result_o;
   logic        ix_o;
   logic        zero_o;

   pu_or1k_pfpu32_i2f_rnd dut (
      .clk           (clk),
      .rst           (rst),
      .flush_i       (flush_i),
      .adv_i         (adv_i),
      .rnd_mode_i    (rnd_mode_i),
      .i2f_rdy_i     (i2f_rdy_i),
      .i2f_sign_i    (i2f_sign_i),
      .i2f_shr_i     (i2f_shr_i),
      .i2f_exp8shr_i (i2f_exp8shr_i),
      .i2f_shl_i     (i2f_shl_i),
      .i2f_exp8shl_i (i2f_exp8shl_i),
      .i2f_exp8sh0_i (i2f_exp8sh0_i),
      .i2f_fract32_i (i2f_fract32_i),
      .rdy_o         (rdy_o),
      .result_o      (result_o),
      .ix_o          (ix_o),
      .zero_o        (zero_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] res;
      logic        ix;
      logic        zero;
   } exp_t;

   exp_t sb[$];
   exp_t mon_exp;
   int   errors = 0;
   int   checks = 0;
   logic last_adv;

   always @(posedge clk) last_adv = adv_i;

   // A result is produced whenever rdy_o is high after an advancing edge.
   always @(negedge clk) begin
      if (last_adv === 1'b1 && rdy_o === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: rdy_o=1 result_o=%h but no op expected", result_o);
         end else begin
            mon_exp = sb.pop_front();
            checks++;
            if (result_o !== mon_exp.res) begin
               errors++;
               $display("FAIL result: got %h expected %h", result_o, mon_exp.res);
            end
            checks++;
            if (ix_o !== mon_exp.ix) begin
               errors++;
               $display("FAIL ix: got %b expected %b (result %h)", ix_o, mon_exp.ix, mon_exp.res);
            end
            checks++;
            if (zero_o !== mon_exp.zero) begin
               errors++;
               $display("FAIL zero: got %b expected %b (result %h)", zero_o, mon_exp.zero, mon_exp.res);
            end
         end
      end
   end

   function automatic exp_t mk(input logic [31:0] res, input logic ix, input logic zero);
      exp_t r;
      r.res  = res;
      r.ix   = ix;
      r.zero = zero;
      return r;
   endfunction

   // Reference: exact integer rounding of the magnitude to 24 significant bits.
   function automatic exp_t ref_i2f(input logic [31:0] val, input logic sgn, input logic [1:0] rm_in);
      exp_t            r;
      int              p;
      int              sh;
      int              e;
      logic [1:0]      rm;
      logic            up;
      longint unsigned mant;
      longint unsigned rem;
      longint unsigned half;
      rm = rm_in;
`ifndef PFPU32_I2F_DIRECTED_RND_EN
      rm = 2'd0;
`endif
      if (val == 32'd0) return mk(32'd0, 1'b0, 1'b1);
      p = 31;
      while (!val[p]) p--;
      e = 127 + p;
      if (p <= 23) begin
         mant = longint'(val) << (23 - p);
         r.ix = 1'b0;
      end else begin
         sh   = p - 23;
         mant = longint'(val) >> sh;
         rem  = longint'(val) & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         r.ix = (rem != 0);
         case (rm)
            2'd0:    up = (rem > half) || (rem == half && mant[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = r.ix && !sgn;
            default: up = r.ix && sgn;
         endcase
         mant = mant + longint'(up);
         if (mant == (64'd1 << 24)) begin
            mant = 64'd1 << 23;
            e++;
         end
      end
      r.res  = {sgn, e[7:0], mant[22:0]};
      r.zero = 1'b0;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives stage-1 fields the way the i2f front end would; unselected fields get junk.
   task automatic drive_op(input logic [31:0] val, input logic sgn, input logic [1:0] rm, input logic vld);
      int p;
      i2f_rdy_i     = vld;
      i2f_sign_i    = sgn;
      rnd_mode_i    = rm;
      i2f_fract32_i = val;
      i2f_shr_i     = 4'd0;
      i2f_shl_i     = 5'($urandom_range(0, 23));
      i2f_exp8shr_i = 8'($urandom);
      i2f_exp8shl_i = 8'($urandom);
      i2f_exp8sh0_i = 8'd0;
      if (val != 32'd0) begin
         p = 31;
         while (!val[p]) p--;
         i2f_exp8sh0_i = 8'd150;
         if (p > 23) begin
            i2f_shr_i     = 4'(p - 23);
            i2f_exp8shr_i = 8'(127 + p);
         end else if (p < 23) begin
            i2f_shl_i     = 5'(23 - p);
            i2f_exp8shl_i = 8'(127 + p);
         end
      end
   endtask

   task automatic issue(input logic [31:0] val, input logic sgn, input logic [1:0] rm, input exp_t e);
      adv_i   = 1'b1;
      flush_i = 1'b0;
      drive_op(val, sgn, rm, 1'b1);
      sb.push_back(e);
      tick();
   endtask

   task automatic drain();
      int n;
      i2f_rdy_i = 1'b0;
      adv_i     = 1'b1;
      flush_i   = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      adv_i = 1'b1;
      flush_i = 1'b0;
      drive_op(32'h0000_1234, 1'b1, 2'd0, 1'b1);
      repeat (3) tick();
      checks++;
      if (rdy_o !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b required 0", rdy_o); end
      checks++;
      if (result_o !== 32'd0) begin errors++; $display("FAIL reset_result: got %h required 0", result_o); end
      checks++;
      if (ix_o !== 1'b0) begin errors++; $display("FAIL reset_ix: got %b required 0", ix_o); end
      checks++;
      if (zero_o !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b required 0", zero_o); end
      rst = 1'b0;
      i2f_rdy_i = 1'b0;
      repeat (2) tick();
      checks++;
      if (rdy_o !== 1'b0) begin errors++; $display("FAIL post_reset_rdy: got %b required 0", rdy_o); end
   endtask

   task automatic test_latency();
      issue(32'd1, 1'b0, 2'd0, mk(32'h3F80_0000, 1'b0, 1'b0));
      i2f_rdy_i = 1'b0;
      checks++;
      if (rdy_o !== 1'b0) begin errors++; $display("FAIL latency_1: rdy_o got %b required 0", rdy_o); end
      tick();
      checks++;
      if (rdy_o !== 1'b1) begin errors++; $display("FAIL latency_2: rdy_o got %b required 1", rdy_o); end
      tick();
      checks++;
      if (rdy_o !== 1'b0) begin errors++; $display("FAIL latency_3: rdy_o got %b required 0", rdy_o); end
      drain();
   endtask

   task automatic test_directed();
      logic [31:0] up_res;
`ifdef PFPU32_I2F_DIRECTED_RND_EN
      up_res = 32'h4B80_0001;
`else
      up_res = 32'h4B80_0000;
`endif
      issue(32'h8000_0000, 1'b1, 2'd0, mk(32'hCF00_0000, 1'b0, 1'b0));
      issue(32'h0100_0001, 1'b0, 2'd0, mk(32'h4B80_0000, 1'b1, 1'b0));
      issue(32'h0100_0001, 1'b0, 2'd1, mk(32'h4B80_0000, 1'b1, 1'b0));
      issue(32'h0100_0001, 1'b0, 2'd2, mk(up_res,        1'b1, 1'b0));
      issue(32'h0100_0001, 1'b0, 2'd3, mk(32'h4B80_0000, 1'b1, 1'b0));
      issue(32'h7FFF_FFFF, 1'b0, 2'd0, mk(32'h4F00_0000, 1'b1, 1'b0));
      issue(32'd0,         1'b1, 2'd0, mk(32'h0000_0000, 1'b0, 1'b1));
      issue(32'h00FF_FFFF, 1'b0, 2'd0, mk(32'h4B7F_FFFF, 1'b0, 1'b0));
      issue(32'h0000_0003, 1'b1, 2'd0, mk(32'hC040_0000, 1'b0, 1'b0));
      drain();
   endtask

   task automatic test_flush();
      adv_i = 1'b1;
      flush_i = 1'b0;
      drive_op(32'd7, 1'b0, 2'd0, 1'b1);
      tick();
      flush_i = 1'b1;
      i2f_rdy_i = 1'b0;
      tick();
      flush_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (rdy_o !== 1'b0) begin errors++; $display("FAIL flush_late: cycle %0d rdy_o got %b required 0", i, rdy_o); end
      end
      drive_op(32'd9, 1'b0, 2'd0, 1'b1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      i2f_rdy_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (rdy_o !== 1'b0) begin errors++; $display("FAIL flush_same: cycle %0d rdy_o got %b required 0", i, rdy_o); end
      end
      issue(32'd10, 1'b0, 2'd0, mk(32'h4120_0000, 1'b0, 1'b0));
      drain();
   endtask

   task automatic test_freeze();
      issue(32'd1, 1'b0, 2'd0, mk(32'h3F80_0000, 1'b0, 1'b0));
      issue(32'h0100_0001, 1'b0, 2'd0, mk(32'h4B80_0000, 1'b1, 1'b0));
      adv_i = 1'b0;
      drive_op(32'd5, 1'b1, 2'd1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (rdy_o !== 1'b1) begin errors++; $display("FAIL freeze_rdy: cycle %0d got %b required 1", i, rdy_o); end
         checks++;
         if (result_o !== 32'h3F80_0000) begin
            errors++;
            $display("FAIL freeze_result: cycle %0d got %h required 3f800000", i, result_o);
         end
      end
      adv_i = 1'b1;
      i2f_rdy_i = 1'b0;
      tick();
      checks++;
      if (result_o !== 32'h4B80_0000) begin errors++; $display("FAIL resume_result: got %h required 4b800000", result_o); end
      tick();
      checks++;
      if (rdy_o !== 1'b0) begin errors++; $display("FAIL resume_drop: rdy_o got %b required 0", rdy_o); end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      logic        s;
      logic [1:0]  rm;
      for (int i = 0; i < 16; i++) begin
         v  = $urandom >> $urandom_range(0, 31);
         s  = 1'($urandom_range(0, 1));
         rm = 2'($urandom_range(0, 3));
         issue(v, s, rm, ref_i2f(v, s, rm));
         if (i >= 1) begin
            checks++;
            if (rdy_o !== 1'b1) begin errors++; $display("FAIL back_to_back: op %0d rdy_o got %b required 1", i, rdy_o); end
         end
      end
      drain();
   endtask

   task automatic test_random_stall();
      logic [31:0] v;
      logic        s;
      logic [1:0]  rm;
      logic        a;
      logic        r;
      flush_i = 1'b0;
      for (int i = 0; i < 80; i++) begin
         v  = $urandom >> $urandom_range(0, 31);
         s  = 1'($urandom_range(0, 1));
         rm = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 4) != 0);
         adv_i = a;
         drive_op(v, s, rm, r);
         if (a && r) sb.push_back(ref_i2f(v, s, rm));
         tick();
      end
      drain();
   endtask

   initial begin
      rst = 1'b1;
      adv_i = 1'b0;
      flush_i = 1'b0;
      drive_op(32'd0, 1'b0, 2'd0, 1'b0);
      test_reset();
      test_latency();
      test_directed();
      test_flush();
      test_freeze();
      test_back_to_back();
      test_random_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

endmodule
